// File: rtl/instruction_fetch_stage.sv
// IF stage of the 16-bit MIPS datapath: owns the PC, drives the instruction memory
// address and registers the fetched word into IF/ID. Handles stall, flush, redirect and HALT.
module instruction_fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_WORD    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_instruction,
  output logic [15:0] ifid_instruction,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ifid_instruction_q, ifid_instruction_d;
  logic [15:0] ifid_pc_plus2_q, ifid_pc_plus2_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_pc;

  assign pc_plus2    = pc_q + 16'd2;
  assign redirect_pc = branch_target & 16'hFFFE;

  // Squash leaves ifid_pc_plus2 untouched; it is meaningless while valid is low.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ifid_instruction_d = ifid_instruction_q;
    ifid_pc_plus2_d    = ifid_pc_plus2_q;
    ifid_valid_d       = ifid_valid_q;

    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_d               = redirect_pc;
          ifid_valid_d       = 1'b0;
          ifid_instruction_d = NOP_WORD;
        end else if (stall) begin
          if (flush) begin
            ifid_valid_d       = 1'b0;
            ifid_instruction_d = NOP_WORD;
          end
        end else if (flush) begin
          pc_d               = pc_plus2;
          ifid_valid_d       = 1'b0;
          ifid_instruction_d = NOP_WORD;
        end else begin
          ifid_instruction_d = imem_instruction;
          ifid_pc_plus2_d    = pc_plus2;
          ifid_valid_d       = 1'b1;
          // A captured HALT parks the PC on its own address.
          if (imem_instruction[15:12] == HALT_OPCODE) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      HALTED: begin
        ifid_valid_d       = 1'b0;
        ifid_instruction_d = NOP_WORD;
        if (branch_taken) begin
          pc_d    = redirect_pc;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= BOOT;
      pc_q               <= RESET_PC & 16'hFFFE;
      ifid_instruction_q <= NOP_WORD;
      ifid_pc_plus2_q    <= 16'h0000;
      ifid_valid_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      ifid_instruction_q <= ifid_instruction_d;
      ifid_pc_plus2_q    <= ifid_pc_plus2_d;
      ifid_valid_q       <= ifid_valid_d;
    end
  end

  assign imem_address     = pc_q;
  assign ifid_instruction = ifid_instruction_q;
  assign ifid_pc_plus2    = ifid_pc_plus2_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; memory stub returns address>>1,
// except a HALT word (0xF000) planted at 0xE000.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_address;
  logic [15:0] imem_instruction;
  logic [15:0] ifid_instruction;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;

  int total;
  int bad;

  instruction_fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus2    (ifid_pc_plus2),
    .ifid_valid       (ifid_valid),
    .halted           (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (imem_address == 16'hE000) imem_instruction = 16'hF000;
    else                          imem_instruction = imem_address >> 1;
  end

  task automatic applyStimulus(input logic st, input logic fl, input logic br,
                               input logic [15:0] tgt);
    stall         = st;
    flush         = fl;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    tick();
    checkOutput("rst_addr",  imem_address, 16'h0000);
    checkOutput("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("rst_instr", ifid_instruction, 16'h0000);
    checkOutput("rst_pp2",   ifid_pc_plus2, 16'h0000);
    checkOutput("rst_halt",  {15'd0, halted}, 16'h0000);

    $display("[TB] boot and sequential fetch");
    rst = 1'b0;
    tick();
    checkOutput("boot_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("boot_addr",  imem_address, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("seq_instr", ifid_instruction, 16'(i));
      checkOutput("seq_pp2",   ifid_pc_plus2, 16'(2 * i + 2));
      checkOutput("seq_valid", {15'd0, ifid_valid}, 16'h0001);
    end

    $display("[TB] stall");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h006E);
    tick();
    checkOutput("br6e_addr", imem_address, 16'h006E);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("pre_stall_instr", ifid_instruction, 16'h0037);
    checkOutput("pre_stall_addr",  imem_address, 16'h0070);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_addr",  imem_address, 16'h0070);
      checkOutput("stall_instr", ifid_instruction, 16'h0037);
      checkOutput("stall_pp2",   ifid_pc_plus2, 16'h0070);
      checkOutput("stall_valid", {15'd0, ifid_valid}, 16'h0001);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("unstall_instr", ifid_instruction, 16'h0038);
    checkOutput("unstall_pp2",   ifid_pc_plus2, 16'h0072);

    $display("[TB] branch over stall");
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0091);
    tick();
    checkOutput("br91_addr",  imem_address, 16'h0090);
    checkOutput("br91_valid", {15'd0, ifid_valid}, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("br91_instr", ifid_instruction, 16'h0048);
    checkOutput("br91_v1",    {15'd0, ifid_valid}, 16'h0001);
    checkOutput("br91_pp2",   ifid_pc_plus2, 16'h0092);

    $display("[TB] wraparound");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFE);
    tick();
    checkOutput("wrap_addr0", imem_address, 16'hFFFE);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("wrap_instr", ifid_instruction, 16'h7FFF);
    checkOutput("wrap_pp2",   ifid_pc_plus2, 16'h0000);
    checkOutput("wrap_addr",  imem_address, 16'h0000);

    $display("[TB] halt");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hE000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("halt_instr", ifid_instruction, 16'hF000);
    checkOutput("halt_valid", {15'd0, ifid_valid}, 16'h0001);
    checkOutput("halt_flag",  {15'd0, halted}, 16'h0001);
    checkOutput("halt_addr",  imem_address, 16'hE000);
    checkOutput("halt_pp2",   ifid_pc_plus2, 16'hE002);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("halted_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("halted_instr", ifid_instruction, 16'h0000);
    checkOutput("halted_addr",  imem_address, 16'hE000);
    checkOutput("halted_flag",  {15'd0, halted}, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
    tick();
    checkOutput("unhalt_flag",  {15'd0, halted}, 16'h0000);
    checkOutput("unhalt_addr",  imem_address, 16'h0010);
    checkOutput("unhalt_valid", {15'd0, ifid_valid}, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("unhalt_instr", ifid_instruction, 16'h0008);
    checkOutput("unhalt_v1",    {15'd0, ifid_valid}, 16'h0001);

    $display("[TB] async reset and flush");
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("arst_addr",  imem_address, 16'h0000);
    checkOutput("arst_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("arst_instr", ifid_instruction, 16'h0000);
    checkOutput("arst_pp2",   ifid_pc_plus2, 16'h0000);
    checkOutput("arst_halt",  {15'd0, halted}, 16'h0000);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("pre_flush_addr", imem_address, 16'h0004);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("flush_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("flush_addr",  imem_address, 16'h0006);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checkOutput("post_flush_instr", ifid_instruction, 16'h0003);
    checkOutput("post_flush_addr",  imem_address, 16'h0008);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
    tick();
    checkOutput("stflush_valid", {15'd0, ifid_valid}, 16'h0000);
    checkOutput("stflush_addr",  imem_address, 16'h0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
